// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access through an IDLE/REQ/WAIT FSM,
// with byte-lane steering for stores, load extraction/extension and a bus timeout.
module lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        busy_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        reg_we_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] rd_wdata_o,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [10:0] TIMEOUT_C = 11'(BUS_TIMEOUT);

    // Handshake: data_req_o is high for every cycle in REQ; an edge with data_gnt_i=1
    // in REQ accepts the request, an edge with data_rvalid_i=1 in WAIT returns data.
    // gnt/rvalid seen in any other state are ignored.
    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic        data_we_q, data_we_d;
    logic [3:0]  data_be_q, data_be_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_wdata_q, data_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] rd_wdata_q, rd_wdata_d;
    logic        err_q, err_d;

    logic        illegal;
    logic        expired;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        illegal = (size_i == 2'b11) ||
                  (size_i == 2'b01 && addr_i[0]) ||
                  (size_i == 2'b10 && addr_i[1:0] != 2'b00);
        expired = (cnt_q + 11'd1) >= TIMEOUT_C;
        shifted = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        sign_d       = sign_q;
        off_d        = off_q;
        rd_d         = rd_q;
        data_we_d    = data_we_q;
        data_be_d    = data_be_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        wr_addr_d    = wr_addr_q;
        rd_wdata_d   = rd_wdata_q;
        reg_we_d     = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        size_d      = size_i;
                        sign_d      = sign_ext_i;
                        off_d       = addr_i[1:0];
                        rd_d        = rd_addr_i;
                        data_we_d   = we_i;
                        data_addr_d = {addr_i[31:2], 2'b00};
                        case (size_i)
                            2'b00: begin
                                data_be_d    = 4'b0001 << addr_i[1:0];
                                data_wdata_d = {4{wdata_i[7:0]}};
                            end
                            2'b01: begin
                                data_be_d    = 4'b0011 << addr_i[1:0];
                                data_wdata_d = {2{wdata_i[15:0]}};
                            end
                            default: begin
                                data_be_d    = 4'b1111;
                                data_wdata_d = wdata_i;
                            end
                        endcase
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 11'd1;
                if (data_gnt_i) begin
                    state_d = WAIT;
                end else if (expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 11'd1;
                if (data_rvalid_i) begin
                    state_d = IDLE;
                    // x0 is hardwired zero, so loads into it never write back
                    if (!data_we_q && rd_q != 5'd0) begin
                        reg_we_d   = 1'b1;
                        wr_addr_d  = rd_q;
                        rd_wdata_d = load_val;
                    end
                end else if (expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            reg_we_q     <= 1'b0;
            wr_addr_q    <= '0;
            rd_wdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            data_we_q    <= data_we_d;
            data_be_q    <= data_be_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            reg_we_q     <= reg_we_d;
            wr_addr_q    <= wr_addr_d;
            rd_wdata_q   <= rd_wdata_d;
            err_q        <= err_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign data_req_o   = (state_q == REQ);
    assign data_we_o    = data_we_q;
    assign data_be_o    = data_be_q;
    assign data_addr_o  = data_addr_q;
    assign data_wdata_o = data_wdata_q;
    assign reg_we_o     = reg_we_q;
    assign wr_addr_o    = wr_addr_q;
    assign rd_wdata_o   = rd_wdata_q;
    assign err_o        = err_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads/stores, lane steering, extension, misalign,
// timeout, reset mid-transaction and back-to-back requests.
module tb_lsu;
    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        reg_we;
    logic [4:0]  wr_addr;
    logic [31:0] rd_wdata;
    logic        err;
    logic [1:0]  dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    lsu #(.BUS_TIMEOUT(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_i         (req),
        .we_i          (we),
        .size_i        (size),
        .sign_ext_i    (sign_ext),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rd_addr_i     (rd_addr),
        .busy_o        (busy),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_rvalid_i (data_rvalid),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_addr_o   (data_addr),
        .data_wdata_o  (data_wdata),
        .data_rdata_i  (data_rdata),
        .reg_we_o      (reg_we),
        .wr_addr_o     (wr_addr),
        .rd_wdata_o    (rd_wdata),
        .err_o         (err),
        .dbg_state_o   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; rd_addr = rd;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; rd_addr = '0; data_gnt = 1'b0; data_rvalid = 1'b0;
        data_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_be", {28'd0, data_be}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        tick();

        // gnt/rvalid in IDLE are ignored
        data_gnt = 1'b1; data_rvalid = 1'b1;
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b0;
        chk("idle_ign_busy", {31'd0, busy}, 32'd0);
        chk("idle_ign_rwe", {31'd0, reg_we}, 32'd0);

        // LB 0x1003, rdata 0x80FF0000, sign-extend, rd=5
        issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 5'd5);
        tick();
        req = 1'b0;
        chk("lb_state", {30'd0, dbg_state}, 32'd1);
        chk("lb_req", {31'd0, data_req}, 32'd1);
        chk("lb_busy", {31'd0, busy}, 32'd1);
        chk("lb_be", {28'd0, data_be}, 32'h8);
        chk("lb_addr", data_addr, 32'h0000_1000);
        chk("lb_we", {31'd0, data_we}, 32'd0);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk("lb_wait_state", {30'd0, dbg_state}, 32'd2);
        chk("lb_wait_req", {31'd0, data_req}, 32'd0);
        data_rvalid = 1'b1; data_rdata = 32'h80FF_0000;
        tick();
        data_rvalid = 1'b0;
        chk("lb_reg_we", {31'd0, reg_we}, 32'd1);
        chk("lb_wr_addr", {27'd0, wr_addr}, 32'd5);
        chk("lb_rd_wdata", rd_wdata, 32'hFFFF_FF80);
        chk("lb_busy_done", {31'd0, busy}, 32'd0);
        tick();
        chk("lb_reg_we_pulse", {31'd0, reg_we}, 32'd0);
        chk("lb_rd_wdata_hold", rd_wdata, 32'hFFFF_FF80);

        // SH 0x2002, wdata 0x1234ABCD
        issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 5'd9);
        tick();
        req = 1'b0;
        chk("sh_be", {28'd0, data_be}, 32'hC);
        chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, data_we}, 32'd1);
        chk("sh_addr", data_addr, 32'h0000_2000);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk("sh_wdata_hold", data_wdata, 32'hABCD_ABCD);
        data_rvalid = 1'b1;
        tick();
        data_rvalid = 1'b0;
        chk("sh_no_reg_we", {31'd0, reg_we}, 32'd0);
        chk("sh_wr_addr_hold", {27'd0, wr_addr}, 32'd5);
        chk("sh_busy", {31'd0, busy}, 32'd0);

        // LW 0x3001 misaligned
        issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 5'd6);
        tick();
        req = 1'b0;
        chk("lw_mis_req", {31'd0, data_req}, 32'd0);
        chk("lw_mis_busy", {31'd0, busy}, 32'd0);
        chk("lw_mis_err", {31'd0, err}, 32'd1);
        chk("lw_mis_reg_we", {31'd0, reg_we}, 32'd0);
        tick();
        chk("lw_mis_err_pulse", {31'd0, err}, 32'd0);

        // illegal size 11 at aligned address
        issue(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 5'd6);
        tick();
        req = 1'b0;
        chk("sz11_err", {31'd0, err}, 32'd1);
        chk("sz11_busy", {31'd0, busy}, 32'd0);

        // LHU 0x4002 with no grant: BUS_TIMEOUT=4
        issue(1'b0, 2'b01, 1'b0, 32'h0000_4002, 32'h0, 5'd3);
        tick();
        req = 1'b0;
        chk("to_be", {28'd0, data_be}, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_reg_we", {31'd0, reg_we}, 32'd0);
        tick();
        chk("to_err_pulse", {31'd0, err}, 32'd0);

        // LW accepted, reset in WAIT, late rvalid
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 5'd4);
        tick();
        req = 1'b0;
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        chk("rw_wait", {30'd0, dbg_state}, 32'd2);
        rst = 1'b1;
        #1;
        chk("rw_async_busy", {31'd0, busy}, 32'd0);
        chk("rw_async_addr", data_addr, 32'd0);
        chk("rw_async_be", {28'd0, data_be}, 32'd0);
        chk("rw_async_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("rw_async_rd_wdata", rd_wdata, 32'd0);
        tick();
        rst = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'h5555_5555;
        tick();
        data_rvalid = 1'b0;
        chk("rw_late_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rw_late_busy", {31'd0, busy}, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'h0, 5'd4);
        tick();
        req = 1'b0;
        chk("rw_next_addr", data_addr, 32'h0000_6004);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF;
        tick();
        data_rvalid = 1'b0;
        chk("rw_next_reg_we", {31'd0, reg_we}, 32'd1);
        chk("rw_next_wr_addr", {27'd0, wr_addr}, 32'd4);
        chk("rw_next_data", rd_wdata, 32'hDEAD_BEEF);

        // LH 0x8002 sign-extend, one cycle of no grant with a stray rvalid in REQ
        issue(1'b0, 2'b01, 1'b1, 32'h0000_8002, 32'h0, 5'd10);
        tick();
        req = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'h8001_0000;
        tick();
        data_rvalid = 1'b0;
        chk("lh_still_req", {31'd0, data_req}, 32'd1);
        chk("lh_no_early_we", {31'd0, reg_we}, 32'd0);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        data_rvalid = 1'b1;
        tick();
        data_rvalid = 1'b0;
        chk("lh_reg_we", {31'd0, reg_we}, 32'd1);
        chk("lh_data", rd_wdata, 32'hFFFF_8001);

        // Back-to-back: LW rd=0 then LBU rd=7 at 0x5001
        issue(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 5'd0);
        tick();
        req = 1'b0;
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'h1111_1111;
        tick();
        data_rvalid = 1'b0;
        chk("b2b_x0_reg_we", {31'd0, reg_we}, 32'd0);
        chk("b2b_x0_busy", {31'd0, busy}, 32'd0);
        chk("b2b_x0_hold", rd_wdata, 32'hFFFF_8001);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0, 5'd7);
        tick();
        req = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_be", {28'd0, data_be}, 32'h2);
        chk("b2b_addr", data_addr, 32'h0000_5000);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        data_rvalid = 1'b1; data_rdata = 32'h0000_9C00;
        tick();
        data_rvalid = 1'b0;
        chk("b2b_reg_we", {31'd0, reg_we}, 32'd1);
        chk("b2b_wr_addr", {27'd0, wr_addr}, 32'd7);
        chk("b2b_data", rd_wdata, 32'h0000_009C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
- REQ-001 SHALL provide parameter: BUS_TIMEOUT, 255, cycles allowed in REQ+WAIT before abort (range 1..1023).
- REQ-002 SHALL provide port: clk_i  in  1  clock; all state updates on rising edge.
- REQ-003 SHALL provide port: rst_i  in  1  reset; asynchronous assert, active-high.
- REQ-004 SHALL provide port: req_i  in  1  memory-op request from execute stage; sampled only in IDLE.
- REQ-005 SHALL provide port: we_i  in  1  1 = store, 0 = load.
- REQ-006 SHALL provide port: size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ-007 SHALL provide port: sign_ext_i  in  1  load sign-extension enable (LB/LH = 1, LBU/LHU = 0).
- REQ-008 SHALL provide port: addr_i  in  32  effective address (ALU add result).
- REQ-009 SHALL provide port: wdata_i  in  32  store data (rs2).
- REQ-010 SHALL provide port: rd_addr_i  in  5  load destination register.
- REQ-011 SHALL provide port: busy_o  out  1  stall to upstream; high whenever state != IDLE.
- REQ-012 SHALL provide ports: data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1, data_we_o out 1, data_be_o out 4, data_addr_o out 32, data_wdata_o out 32, data_rdata_i in 32 (data-memory bus).
- REQ-013 SHALL provide ports: reg_we_o out 1, wr_addr_o out 5, rd_wdata_o out 32 (writeback), err_o out 1 (misalign/illegal/timeout pulse).

Function
- REQ-014 FSM SHALL have states IDLE, REQ, WAIT; all outputs except busy_o/data_req_o SHALL be registered.
- REQ-015 IDLE with req_i=1 and legal aligned access SHALL latch we, size, sign_ext, addr[1:0], rd_addr, bus fields, and move to REQ next edge.
- REQ-016 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size_i=11 SHALL stay IDLE, issue no bus request, pulse err_o one cycle after the request edge, and not write back.
- REQ-017 data_req_o SHALL be 1 exactly in REQ; bus fields SHALL hold stable while in REQ.
- REQ-018 REQ with data_gnt_i=1 at an edge SHALL move to WAIT; gnt outside REQ SHALL be ignored.
- REQ-019 WAIT with data_rvalid_i=1 SHALL move to IDLE; rvalid outside WAIT SHALL be ignored.
- REQ-020 data_addr_o SHALL be {addr[31:2],2'b00}; data_we_o = we.
- REQ-021 data_be_o SHALL be 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
- REQ-022 data_wdata_o SHALL be {4{wdata[7:0]}} (byte), {2{wdata[15:0]}} (half), wdata (word).
- REQ-023 Load data SHALL be data_rdata_i >> (8*addr[1:0]), truncated to size, then sign- or zero-extended to 32 per sign_ext.
- REQ-024 For a load, the cycle after the rvalid edge SHALL show reg_we_o=1 for one cycle with wr_addr_o=rd_addr, rd_wdata_o=extended data; reg_we_o SHALL stay 0 if rd_addr=0 or for stores.
- REQ-025 rd_wdata_o and wr_addr_o SHALL hold their last value when reg_we_o=0.
- REQ-026 A counter SHALL clear on entering REQ and increment each cycle in REQ/WAIT; on reaching BUS_TIMEOUT the FSM SHALL return to IDLE, pulse err_o one cycle, not write back.
- REQ-027 Minimum load latency: request edge N -> REQ cycle N+1 -> gnt edge -> WAIT -> rvalid edge -> reg_we_o high in the following cycle (4 cycles with zero-wait gnt/rvalid).
- REQ-028 busy_o SHALL deassert in the same cycle the FSM is IDLE, so back-to-back requests accept on the next edge.

Reset
- REQ-029 rst_i=1 SHALL immediately force state IDLE, counter 0, and reg_we_o, err_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, wr_addr_o, rd_wdata_o to 0.
- REQ-030 Reset mid-transaction SHALL abandon it; a late rvalid after reset release SHALL be ignored and cause no writeback.

Verification
- REQ-031 LB addr 0x1003, rdata 0x80FF_0000, sign_ext=1, rd=5 -> be 1000, addr 0x1000, reg_we_o pulse, wr_addr 5, rd_wdata 0xFFFF_FF80.
- REQ-032 SH addr 0x2002, wdata 0x1234_ABCD -> be 1100, data_wdata 0xABCD_ABCD, data_we 1, no reg_we_o.
- REQ-033 LW addr 0x3001 -> no data_req_o, err_o pulse, busy_o stays 0.
- REQ-034 LHU addr 0x4002, gnt held low, BUS_TIMEOUT=4 -> return to IDLE after 4 cycles, err_o pulse, no writeback.
- REQ-035 LW accepted, rst_i pulsed in WAIT, then rvalid -> outputs 0, no reg_we_o, next request served normally.
- REQ-036 Back-to-back LW rd=0 then LBU rd=7 addr 0x5001 rdata 0x0000_9C00 -> first no reg_we_o, second rd_wdata 0x0000_009C.
